// File: rtl/cache_pkg.sv
// cache_pkg: shared arbiter state encoding, block geometry and address helpers
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFILL  = 2'd1,
        DFILL  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W = 3;
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'h000F;

    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & ~BLOCK_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/block_fill_seq.sv
// block_fill_seq: issue/receive counters, word address generation and last-word detect for a block fill
module block_fill_seq
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic [15:0]           base_addr,
    input  logic                  mem_data_valid,
    output logic                  issue,
    output logic [15:0]           issue_addr,
    output logic [WORD_IDX_W-1:0] word_idx,
    output logic                  last
);

    // The extra MSB on ic marks "all words issued" so issuing stops instead of wrapping.
    logic [WORD_IDX_W:0]   ic;
    logic [WORD_IDX_W-1:0] rc;

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            ic <= '0;
            rc <= '0;
        end else begin
            if (issue) ic <= ic + 1'b1;
            if (mem_data_valid) rc <= rc + 1'b1;
        end
    end

    assign issue      = active && !ic[WORD_IDX_W];
    assign issue_addr = block_base(base_addr) | 16'({ic[WORD_IDX_W-1:0], 1'b0});
    assign word_idx   = rc;
    assign last       = active && mem_data_valid && rc == WORD_IDX_W'(BLOCK_WORDS - 1);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares pipelined main memory between I-cache fills and D-cache fills/stores
module mem_arbiter
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_req,
    input  logic [15:0]           icache_addr,
    output logic                  icache_grant,
    output logic                  icache_fill_vld,
    output logic                  icache_done,
    input  logic                  dcache_req,
    input  logic                  dcache_wr,
    input  logic [15:0]           dcache_addr,
    input  logic [15:0]           dcache_wdata,
    output logic                  dcache_grant,
    output logic                  dcache_fill_vld,
    output logic                  dcache_done,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [15:0]           fill_data,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [15:0]           mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_data_valid
);

    localparam int WW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;

    arb_state_t            state, state_n;
    logic [15:0]           addr_q, wdata_q;
    logic [WW-1:0]         wc;
    logic                  fill_active, issue, last, wr_issue, wr_last;
    logic [15:0]           issue_addr;
    logic [WORD_IDX_W-1:0] word_idx;

    assign fill_active = state == IFILL || state == DFILL;
    assign wr_issue    = state == DWRITE && wc == '0;
    assign wr_last     = state == DWRITE && wc == WW'(MEM_LATENCY - 1);

    block_fill_seq u_seq (
        .clk           (clk),
        .rst           (rst),
        .active        (fill_active),
        .base_addr     (addr_q),
        .mem_data_valid(mem_data_valid),
        .issue         (issue),
        .issue_addr    (issue_addr),
        .word_idx      (word_idx),
        .last          (last)
    );

    // Request fields are captured every IDLE cycle; the value latched on the exit edge is the one used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wc      <= '0;
        end else begin
            state <= state_n;
            wc    <= state == DWRITE ? wc + 1'b1 : '0;
            if (state == IDLE) begin
                addr_q  <= dcache_req ? dcache_addr : icache_addr;
                wdata_q <= dcache_wdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:         state_n = dcache_req ? (dcache_wr ? DWRITE : DFILL) : (icache_req ? IFILL : IDLE);
            IFILL, DFILL: state_n = last ? IDLE : state;
            DWRITE:       state_n = wr_last ? IDLE : DWRITE;
            default:      state_n = IDLE;
        endcase
    end

    always_comb begin
        icache_grant    = state == IFILL;
        dcache_grant    = state == DFILL || state == DWRITE;
        icache_fill_vld = state == IFILL && mem_data_valid;
        dcache_fill_vld = state == DFILL && mem_data_valid;
        icache_done     = state == IFILL && last;
        dcache_done     = (state == DFILL && last) || wr_last;
        fill_word       = word_idx;
        fill_data       = mem_rdata;
        mem_en          = issue || wr_issue;
        mem_wr          = wr_issue;
        mem_addr        = issue ? issue_addr : (wr_issue ? {addr_q[15:1], 1'b0} : 16'h0000);
        mem_wdata       = wr_issue ? wdata_q : 16'h0000;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter fills, stores, priority, reset abort and latency
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        icache_req = 1'b0, dcache_req = 1'b0, dcache_wr = 1'b0;
    logic [15:0] icache_addr = '0, dcache_addr = '0, dcache_wdata = '0;
    logic        icache_grant, icache_fill_vld, icache_done;
    logic        dcache_grant, dcache_fill_vld, dcache_done;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_data_valid;

    logic        l1_ireq = 1'b0;
    logic [15:0] l1_iaddr = '0;
    logic        l1_igrant, l1_ivld, l1_idone, l1_dgrant, l1_dvld, l1_ddone;
    logic [2:0]  l1_word;
    logic [15:0] l1_fdata, l1_addr, l1_wdata;
    logic        l1_en, l1_wr;
    logic        l1_v = 1'b0;
    logic [15:0] l1_d = '0;

    int checks = 0, errors = 0;

    logic [3:0]  pv = '0;
    logic [15:0] pd0 = '0, pd1 = '0, pd2 = '0, pd3 = '0;
    logic        stray = 1'b0;
    int          wr_cnt = 0;
    logic [15:0] wr_addr = '0, wr_data = '0;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Expected {ig, dg, en, wr, ivld, dvld, idone, ddone} at cycle j after a fill request seen at j=0.
    function automatic logic [7:0] fill_ctl(input int j, input bit own_d, input int lat);
        logic g, en, v, dn;
        g  = j >= 1 && j <= 8 + lat;
        en = j >= 1 && j <= 8;
        v  = j >= 1 + lat && j <= 8 + lat;
        dn = j == 8 + lat;
        return {g && !own_d, g && own_d, en, 1'b0, v && !own_d, v && own_d, dn && !own_d, dn && own_d};
    endfunction

    assign mem_data_valid = pv[3] | stray;
    assign mem_rdata      = pd3;

    always @(posedge clk) begin
        pv  <= {pv[2:0], mem_en && !mem_wr};
        pd0 <= mem_f(mem_addr);
        pd1 <= pd0;
        pd2 <= pd1;
        pd3 <= pd2;
        l1_v <= l1_en && !l1_wr;
        l1_d <= mem_f(l1_addr);
        if (mem_en && mem_wr) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    mem_arbiter #(.MEM_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_grant(icache_grant), .icache_fill_vld(icache_fill_vld), .icache_done(icache_done),
        .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_grant(dcache_grant), .dcache_fill_vld(dcache_fill_vld), .dcache_done(dcache_done),
        .fill_word(fill_word), .fill_data(fill_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
    );

    mem_arbiter #(.MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .icache_req(l1_ireq), .icache_addr(l1_iaddr),
        .icache_grant(l1_igrant), .icache_fill_vld(l1_ivld), .icache_done(l1_idone),
        .dcache_req(1'b0), .dcache_wr(1'b0), .dcache_addr(16'h0000), .dcache_wdata(16'h0000),
        .dcache_grant(l1_dgrant), .dcache_fill_vld(l1_dvld), .dcache_done(l1_ddone),
        .fill_word(l1_word), .fill_data(l1_fdata),
        .mem_en(l1_en), .mem_wr(l1_wr), .mem_addr(l1_addr), .mem_wdata(l1_wdata),
        .mem_rdata(l1_d), .mem_data_valid(l1_v)
    );

    wire [7:0] obs    = {icache_grant, dcache_grant, mem_en, mem_wr, icache_fill_vld, dcache_fill_vld, icache_done, dcache_done};
    wire [7:0] l1_obs = {l1_igrant, l1_dgrant, l1_en, l1_wr, l1_ivld, l1_dvld, l1_idone, l1_ddone};

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 8'h00 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 || fill_word !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h word=%0d, required all zero", obs, mem_addr, mem_wdata, fill_word);
        end
        checks++;
        if (fill_data !== mem_rdata) begin
            errors++;
            $display("FAIL reset_fill_data: got %h, required %h", fill_data, mem_rdata);
        end
        checks++;
        if (l1_obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_l1_outputs: ctl=%b, required 00000000", l1_obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_ifill();
        logic [7:0] exp;
        icache_addr = 16'h1236;
        icache_req  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp = fill_ctl(k, 1'b0, 4);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ifill_ctl k=%0d: got %b, required %b", k, obs, exp);
            end
            if (exp[5]) begin
                checks++;
                if (mem_addr !== 16'h1230 + 16'(2 * (k - 1))) begin
                    errors++;
                    $display("FAIL ifill_addr k=%0d: got %h, required %h", k, mem_addr, 16'h1230 + 16'(2 * (k - 1)));
                end
            end
            if (exp[3]) begin
                checks++;
                if (fill_word !== 3'(k - 5) || fill_data !== mem_f(16'h1230 + 16'(2 * (k - 5)))) begin
                    errors++;
                    $display("FAIL ifill_data k=%0d: word=%0d data=%h, required word=%0d data=%h",
                             k, fill_word, fill_data, k - 5, mem_f(16'h1230 + 16'(2 * (k - 5))));
                end
            end
            if (k == 12) icache_req = 1'b0;
        end
    endtask

    // D fill to dbase with an I fill of 0x2228 queued behind it; early drops dcache_req at k=3 and raises I then.
    task automatic dual_fill(input logic [15:0] dbase, input bit early);
        logic [7:0]  exp;
        logic [15:0] ea;
        int          ji;
        dcache_addr = dbase;
        dcache_wr   = 1'b0;
        icache_addr = 16'h2228;
        dcache_req  = 1'b1;
        icache_req  = !early;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            ji  = k - 13;
            exp = fill_ctl(k, 1'b1, 4) | fill_ctl(ji, 1'b0, 4);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL dual_ctl early=%0d k=%0d: got %b, required %b", early, k, obs, exp);
            end
            if (exp[5]) begin
                ea = k <= 8 ? (dbase & 16'hFFF0) + 16'(2 * (k - 1)) : 16'h2220 + 16'(2 * (ji - 1));
                checks++;
                if (mem_addr !== ea) begin
                    errors++;
                    $display("FAIL dual_addr early=%0d k=%0d: got %h, required %h", early, k, mem_addr, ea);
                end
            end
            if (exp[2] || exp[3]) begin
                ea = exp[2] ? (dbase & 16'hFFF0) + 16'(2 * (k - 5)) : 16'h2220 + 16'(2 * (ji - 5));
                checks++;
                if (fill_word !== 3'(exp[2] ? k - 5 : ji - 5) || fill_data !== mem_f(ea)) begin
                    errors++;
                    $display("FAIL dual_data early=%0d k=%0d: word=%0d data=%h, required data=%h", early, k, fill_word, fill_data, mem_f(ea));
                end
            end
            if (early && k == 3) begin
                dcache_req = 1'b0;
                icache_req = 1'b1;
            end
            if (k == 12) dcache_req = 1'b0;
            if (k == 25) icache_req = 1'b0;
        end
    endtask

    task automatic test_priority();
        dual_fill(16'h4000, 1'b0);
    endtask

    task automatic test_req_drop();
        dual_fill(16'h7F1E, 1'b1);
    endtask

    task automatic test_store();
        logic [7:0] exp;
        int         w0;
        w0           = wr_cnt;
        dcache_addr  = 16'h0103;
        dcache_wdata = 16'hBEEF;
        dcache_wr    = 1'b1;
        dcache_req   = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp = {1'b0, k <= 4, k == 1, k == 1, 1'b0, 1'b0, 1'b0, k == 4};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL store_ctl k=%0d: got %b, required %b", k, obs, exp);
            end
            if (k == 1) begin
                checks++;
                if (mem_addr !== 16'h0102 || mem_wdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL store_bus: addr=%h data=%h, required 0102 BEEF", mem_addr, mem_wdata);
                end
            end
            if (k == 4) dcache_req = 1'b0;
        end
        dcache_wr = 1'b0;
        checks++;
        if (wr_cnt !== w0 + 1 || wr_addr !== 16'h0102 || wr_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_count: writes=%0d addr=%h data=%h, required 1 0102 BEEF", wr_cnt - w0, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp;
        icache_addr = 16'h1236;
        icache_req  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp = k <= 6 ? fill_ctl(k, 1'b0, 4) : 8'h00;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort_ctl k=%0d: got %b, required %b", k, obs, exp);
            end
            if (k >= 7) begin
                checks++;
                if (mem_addr !== 16'h0 || fill_word !== 3'd0) begin
                    errors++;
                    $display("FAIL abort_idle k=%0d: addr=%h word=%0d, required 0 0", k, mem_addr, fill_word);
                end
            end
            if (k == 6) begin
                rst        = 1'b1;
                icache_req = 1'b0;
            end
            if (k == 7) rst = 1'b0;
        end
    endtask

    task automatic test_stray_valid();
        stray = 1'b1;
        #2;
        checks++;
        if (icache_fill_vld !== 1'b0 || dcache_fill_vld !== 1'b0 || fill_word !== 3'd0) begin
            errors++;
            $display("FAIL stray_vld: ivld=%b dvld=%b word=%0d, required 0 0 0", icache_fill_vld, dcache_fill_vld, fill_word);
        end
        @(negedge clk);
        stray = 1'b0;
        checks++;
        if (obs !== 8'h00 || fill_word !== 3'd0) begin
            errors++;
            $display("FAIL stray_state: ctl=%b word=%0d, required 00000000 0", obs, fill_word);
        end
        test_ifill();
    endtask

    task automatic test_latency1();
        logic [7:0] exp;
        l1_iaddr = 16'h1236;
        l1_ireq  = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            exp = fill_ctl(k, 1'b0, 1);
            checks++;
            if (l1_obs !== exp) begin
                errors++;
                $display("FAIL lat1_ctl k=%0d: got %b, required %b", k, l1_obs, exp);
            end
            if (exp[5]) begin
                checks++;
                if (l1_addr !== 16'h1230 + 16'(2 * (k - 1))) begin
                    errors++;
                    $display("FAIL lat1_addr k=%0d: got %h, required %h", k, l1_addr, 16'h1230 + 16'(2 * (k - 1)));
                end
            end
            if (exp[3]) begin
                checks++;
                if (l1_word !== 3'(k - 2) || l1_fdata !== mem_f(16'h1230 + 16'(2 * (k - 2)))) begin
                    errors++;
                    $display("FAIL lat1_data k=%0d: word=%0d data=%h, required word=%0d", k, l1_word, l1_fdata, k - 2);
                end
            end
            if (k == 9) l1_ireq = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ifill();
        test_priority();
        test_store();
        test_reset_abort();
        test_req_drop();
        test_stray_valid();
        test_latency1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
